// File: rtl/result_writer.sv
// Write-back stage: takes wide result vectors from the PE array and streams them
// one byte per cycle into the output buffer over startAddr..finalAddr.
module result_writer #(
    parameter int MaxWidth  = 9,
    parameter int Depth     = 32,
    parameter int DataWidth = 8,
    parameter int AddrWidth = $clog2(Depth),
    parameter int IdxWidth  = $clog2(MaxWidth)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          writeStart,
    input  logic [AddrWidth-1:0]          startAddr,
    input  logic [AddrWidth-1:0]          finalAddr,
    input  logic                          vecValid,
    output logic                          vecReady,
    input  logic [MaxWidth*DataWidth-1:0] dataIn,
    output logic                          writeEn,
    output logic [AddrWidth-1:0]          writeAddr,
    output logic [DataWidth-1:0]          writeData,
    output logic                          busy,
    output logic                          finished
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VEC,
        WRITE,
        DONE
    } state_t;

    state_t                        state;
    state_t                        nextState;
    logic [AddrWidth-1:0]          ptr;
    logic [AddrWidth-1:0]          endAddr;
    logic [IdxWidth-1:0]           idx;
    logic [MaxWidth*DataWidth-1:0] vecReg;
    logic [DataWidth-1:0]          laneData;
    logic                          jobStart;
    logic                          vecAccept;
    logic                          lastAddr;
    logic                          lastLane;

    assign vecReady = (state == WAIT_VEC);
    assign busy     = (state != IDLE);
    assign lastAddr = (ptr == endAddr);
    assign lastLane = (idx == IdxWidth'(MaxWidth - 1));
    assign laneData = vecReg[int'(idx)*DataWidth +: DataWidth];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        nextState = state;
        jobStart  = 1'b0;
        vecAccept = 1'b0;
        case (state)
            IDLE: begin
                if (writeStart) begin
                    jobStart  = 1'b1;
                    nextState = (startAddr <= finalAddr) ? WAIT_VEC : DONE;
                end
            end
            WAIT_VEC: begin
                if (vecValid) begin
                    vecAccept = 1'b1;
                    nextState = WRITE;
                end
            end
            WRITE: begin
                if (lastAddr) begin
                    nextState = DONE;
                end else if (lastLane) begin
                    nextState = WAIT_VEC;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            endAddr   <= '0;
            idx       <= '0;
            writeEn   <= 1'b0;
            writeAddr <= '0;
            writeData <= '0;
            finished  <= 1'b0;
        end else begin
            writeEn <= (state == WRITE);
            if (jobStart) begin
                ptr      <= startAddr;
                endAddr  <= finalAddr;
                finished <= 1'b0;
            end
            if (vecAccept) begin
                idx <= '0;
            end
            if (state == WRITE) begin
                writeAddr <= ptr;
                writeData <= laneData;
                idx       <= idx + IdxWidth'(1);
                // ptr parks on endAddr so the address never wraps past the job
                if (!lastAddr) begin
                    ptr <= ptr + AddrWidth'(1);
                end
            end
            if (state == DONE) begin
                finished <= 1'b1;
            end
        end
    end

    // NOTE: vector holding register is pure datapath; the FSM says when it is valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (vecAccept) begin
            vecReg <= dataIn;
        end
    end

endmodule

// File: tb/tb_result_writer.sv
// Self-checking bench for result_writer: directed jobs plus random jobs compared
// against a byte-list model built from the address range and the accepted vectors.
module tb_result_writer;

    localparam int MW = 9;
    localparam int DW = 8;
    localparam int AW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             writeStart;
    logic [AW-1:0]    startAddr;
    logic [AW-1:0]    finalAddr;
    logic             vecValid;
    logic             vecReady;
    logic [MW*DW-1:0] dataIn;
    logic             writeEn;
    logic [AW-1:0]    writeAddr;
    logic [DW-1:0]    writeData;
    logic             busy;
    logic             finished;

    result_writer dut (
        .clk       (clk),
        .rst       (rst),
        .writeStart(writeStart),
        .startAddr (startAddr),
        .finalAddr (finalAddr),
        .vecValid  (vecValid),
        .vecReady  (vecReady),
        .dataIn    (dataIn),
        .writeEn   (writeEn),
        .writeAddr (writeAddr),
        .writeData (writeData),
        .busy      (busy),
        .finished  (finished)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int             cyc = 0;
    int             passCount = 0;
    int             failCount = 0;
    int             totalCount = 0;
    int             readySeen = 0;
    wr_t            wrQ[$];
    int             acceptQ[$];
    logic [MW*DW-1:0] vecs[4];

    always @(posedge clk) cyc <= cyc + 1;

    // Observed write strobes and ready cycles, tagged with the edge that produced them
    always @(negedge clk) begin
        if (writeEn) wrQ.push_back('{cyc, writeAddr, writeData});
        if (vecReady) readySeen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] laneOf(input logic [MW*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    task automatic startJob(input int s, input int f, output int startEdge);
        @(posedge clk);
        #1;
        writeStart = 1'b1;
        startAddr  = AW'(s);
        finalAddr  = AW'(f);
        startEdge  = cyc + 1;
        @(posedge clk);
        #1;
        writeStart = 1'b0;
        startAddr  = AW'($urandom);
        finalAddr  = AW'($urandom);
    endtask

    task automatic sendVec(input string tag, input logic [MW*DW-1:0] v, input int late);
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (vecReady) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            check({tag, "_ready_timeout"}, vecReady, 1);
            return;
        end
        repeat (late) @(negedge clk);
        #1;
        vecValid = 1'b1;
        dataIn   = v;
        acceptQ.push_back(cyc + 1);
        @(posedge clk);
        #1;
        vecValid = 1'b0;
        dataIn   = {8'($urandom), 32'($urandom), 32'($urandom)};
    endtask

    task automatic runJob(input string tag, input int s, input int f, input int late, input bit inject);
        int n, nv, startEdge, finCyc, expFin, m, k;
        n  = (s <= f) ? f - s + 1 : 0;
        nv = (n + MW - 1) / MW;
        wrQ.delete();
        acceptQ.delete();
        readySeen = 0;
        startJob(s, f, startEdge);
        check({tag, "_fin_clr"}, finished, 0);
        check({tag, "_busy"}, busy, 1);
        for (int v = 0; v < nv; v++) sendVec(tag, vecs[v], (v == 1) ? late : 0);
        if (inject) begin
            writeStart = 1'b1;
            startAddr  = AW'(20);
            finalAddr  = AW'(25);
            @(posedge clk);
            #1;
            writeStart = 1'b0;
        end
        finCyc = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (finished) begin
                finCyc = cyc;
                break;
            end
        end
        check({tag, "_finished"}, finished, 1);
        check({tag, "_nwrites"}, wrQ.size(), n);
        check({tag, "_naccept"}, acceptQ.size(), nv);
        m = (wrQ.size() < n) ? wrQ.size() : n;
        for (k = 0; k < m; k++) begin
            check($sformatf("%s_addr%0d", tag, k), wrQ[k].addr, s + k);
            check($sformatf("%s_data%0d", tag, k), wrQ[k].data, laneOf(vecs[k / MW], k % MW));
            check($sformatf("%s_cyc%0d", tag, k), wrQ[k].cyc,
                  ((k / MW < acceptQ.size()) ? acceptQ[k / MW] : 0) + 1 + k % MW);
        end
        if (n == 0) begin
            expFin = startEdge + 1;
            check({tag, "_noready"}, readySeen, 0);
        end else begin
            expFin = (wrQ.size() > 0) ? wrQ[wrQ.size() - 1].cyc + 1 : -1;
        end
        check({tag, "_fin_time"}, finCyc, expFin);
        @(negedge clk);
        check({tag, "_fin_hold"}, finished, 1);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_we_off"}, writeEn, 0);
    endtask

    initial begin
        int s, f;
        bit hit;
        rst        = 1'b1;
        writeStart = 1'b0;
        startAddr  = '0;
        finalAddr  = '0;
        vecValid   = 1'b0;
        dataIn     = '0;
        repeat (3) @(negedge clk);
        check("rst_we", writeEn, 0);
        check("rst_addr", writeAddr, 0);
        check("rst_data", writeData, 0);
        check("rst_fin", finished, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", vecReady, 0);
        rst = 1'b0;

        // Full single vector, lanes 01..09
        vecs[0] = 72'h090807060504030201;
        runJob("full", 0, 8, 0, 0);

        // Two vectors, second one held back 3 cycles
        vecs[0] = {8'($urandom), 32'($urandom), 32'($urandom)};
        vecs[1] = {8'($urandom), 32'($urandom), 32'($urandom)};
        runJob("late", 4, 21, 3, 0);
        check("late_gap", (wrQ.size() > 9) ? wrQ[9].cyc - wrQ[8].cyc : -1, 5);

        // Partial vector: only lanes 0..4 written
        vecs[0] = 72'h998877665544332211;
        runJob("partial", 0, 4, 0, 0);

        // Empty range
        runJob("empty", 10, 3, 0, 0);

        // Reset after the third write, then a clean job
        vecs[0] = {8'($urandom), 32'($urandom), 32'($urandom)};
        wrQ.delete();
        acceptQ.delete();
        begin
            int se;
            startJob(0, 8, se);
        end
        sendVec("rstmid", vecs[0], 0);
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wrQ.size() >= 3) begin
                hit = 1;
                break;
            end
        end
        check("rstmid_3writes", wrQ.size(), 3);
        rst = 1'b1;
        #1;
        check("rstmid_we", writeEn, 0);
        check("rstmid_fin", finished, 0);
        check("rstmid_busy", busy, 0);
        wrQ.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rstmid_nowrites", wrQ.size(), 0);
        check("rstmid_fin_after", finished, 0);
        vecs[0] = {8'($urandom), 32'($urandom), 32'($urandom)};
        runJob("rerun", 0, 8, 0, 0);

        // writeStart during WRITE is ignored
        vecs[0] = {8'($urandom), 32'($urandom), 32'($urandom)};
        runJob("inject", 2, 10, 0, 1);

        // Random ranges, data and second-vector delays
        for (int j = 0; j < 6; j++) begin
            s = $urandom_range(0, 31);
            f = $urandom_range(s, 31);
            for (int v = 0; v < 4; v++) vecs[v] = {8'($urandom), 32'($urandom), 32'($urandom)};
            runJob($sformatf("rnd%0d", j), s, f, $urandom_range(0, 4), 0);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
